mem_arbiter: RTL and testbench

Arbitrates the single-ported, multi-cycle main memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. It sequences each access through a small FSM, returns read data with a one-cycle done pulse, and drives the stall signals the pipeline registers use to freeze. Data accesses have fixed priority over fetches.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the IF/MEM main-memory arbiter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    typedef enum logic {
        FETCH,
        DATA
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/complete and memory-command bundle between the pipeline, the arbiter and main memory.
interface mem_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              stall_if;
    logic              stall_pipe;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              mem_err;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_data_valid,
        output if_done, if_rdata, d_done, d_rdata, stall_if, stall_pipe,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_err
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_data_valid,
        input  if_done, if_rdata, d_done, d_rdata, stall_if, stall_pipe,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter, data over fetch; write done 2 cycles after request, read 2+L, timeout 3+TIMEOUT.
// No backpressure on memory; requesters are held off through stall_if/stall_pipe until their done pulse.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;
    logic              mem_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= FETCH;
            cnt         <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.d_req) begin
                        owner       <= DATA;
                        mem_wr_q    <= bus.d_wr;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        mem_en_q    <= 1'b1;
                        state       <= ISSUE;
                    end else if (bus.if_req) begin
                        owner       <= FETCH;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_en_q    <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt <= '0;
                    if (mem_wr_q) begin
                        if (owner == DATA) d_done_q  <= 1'b1;
                        else               if_done_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    // A missing return still completes (with zero data) so the pipeline cannot hang.
                    if (bus.mem_data_valid || cnt == TO_CNT) begin
                        if (!bus.mem_data_valid) mem_err_q <= 1'b1;
                        if (owner == DATA) begin
                            d_rdata_q <= bus.mem_data_valid ? bus.mem_rdata : '0;
                            d_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_data_valid ? bus.mem_rdata : '0;
                            if_done_q  <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.if_done    = if_done_q;
    assign bus.d_done     = d_done_q;
    assign bus.mem_err    = mem_err_q;
    assign bus.stall_if   = bus.if_req & ~if_done_q;
    assign bus.stall_pipe = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: commands, completions and their cycles checked against queued expectations.
module tb_mem_arbiter;
    import cpu_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } cmd_t;

    typedef struct {
        int          lat;
        logic [15:0] data;
    } rd_t;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   spur_req = 0;
    logic [15:0] spur_data = 16'h0;
    logic [15:0] f_last = 16'h0;
    logic [15:0] d_last = 16'h0;

    cmd_t  cmdq[$];
    rd_t   rdq[$];
    done_t fq[$];
    done_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion and command monitor.
    initial begin
        forever begin
            cmd_t  c;
            done_t e;
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_en) begin
                    if (cmdq.size() == 0) check("stray_mem_en", 1, 0);
                    else begin
                        c = cmdq.pop_front();
                        check("cmd_wr", bus.mem_wr, c.wr);
                        check("cmd_addr", bus.mem_addr, c.addr);
                        if (c.wr) check("cmd_wdata", bus.mem_wdata, c.wdata);
                        check("cmd_cycle", cyc, c.cyc);
                    end
                end
                if (bus.if_done) begin
                    if (fq.size() == 0) check("stray_if_done", 1, 0);
                    else begin
                        e = fq.pop_front();
                        check("if_rdata", bus.if_rdata, e.rdata);
                        check("if_done_cycle", cyc, e.cyc);
                    end
                end
                if (bus.d_done) begin
                    if (dq.size() == 0) check("stray_d_done", 1, 0);
                    else begin
                        e = dq.pop_front();
                        check("d_rdata", bus.d_rdata, e.rdata);
                        check("d_done_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Memory model: returns read data L cycles after the command strobe (lat <= 0: never).
    initial begin
        int          pend;
        int          spur_seen;
        logic [15:0] pdata;
        rd_t         r;
        pend      = 0;
        spur_seen = 0;
        pdata     = 16'h0;
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = 16'h0;
        forever begin
            @(negedge clk);
            bus.mem_data_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_data_valid = 1'b1;
                    bus.mem_rdata      = pdata;
                end
            end
            if (spur_req != spur_seen) begin
                spur_seen          = spur_req;
                bus.mem_data_valid = 1'b1;
                bus.mem_rdata      = spur_data;
            end
            if (!rst && bus.mem_en && !bus.mem_wr && rdq.size() > 0) begin
                r = rdq.pop_front();
                if (r.lat > 0) begin
                    pend  = r.lat;
                    pdata = r.data;
                end
            end
        end
    end

    task automatic start_fetch(input logic [15:0] a, input logic [15:0] ret, input int lat,
                               input int en_off, input int done_off);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        cmdq.push_back('{1'b0, a, 16'h0, cyc + en_off});
        rdq.push_back('{lat, ret});
        fq.push_back('{ret, cyc + done_off});
    endtask

    task automatic start_data(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                              input logic [15:0] ret, input int lat, input int en_off,
                              input int done_off, input logic [15:0] exp_rdata);
        bus.d_req   = 1'b1;
        bus.d_wr    = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        cmdq.push_back('{wr, a, wd, cyc + en_off});
        if (!wr) rdq.push_back('{lat, ret});
        dq.push_back('{exp_rdata, cyc + done_off});
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.if_done) begin
                check("stall_if_at_done", bus.stall_if, 0);
                bus.if_req = 1'b0;
                return;
            end
            check("stall_if_busy", bus.stall_if, 1);
        end
        check("fetch_wait_bound", 0, 1);
        bus.if_req = 1'b0;
    endtask

    task automatic wait_data();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.d_done) begin
                check("stall_pipe_at_done", bus.stall_pipe, 0);
                bus.d_req = 1'b0;
                return;
            end
            check("stall_pipe_busy", bus.stall_pipe, 1);
        end
        check("data_wait_bound", 0, 1);
        bus.d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] v;
        logic [15:0] a;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_done", bus.if_done, 0);
        check("rst_d_done", bus.d_done, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_mem_err", bus.mem_err, 0);
        check("rst_stall_if", bus.stall_if, 0);
        check("rst_stall_pipe", bus.stall_pipe, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch alone, L=4.
        @(negedge clk);
        start_fetch(16'h0040, 16'hA5A5, 4, 1, 6);
        #1 check("stall_if_cycle0", bus.stall_if, 1);
        wait_fetch();
        f_last = 16'hA5A5;

        // Simultaneous: data read wins, fetch follows on the next IDLE visit.
        @(negedge clk);
        start_data(1'b0, 16'h2000, 16'h0, 16'h5A5A, 4, 1, 6, 16'h5A5A);
        start_fetch(16'h0010, 16'h1357, 2, 8, 11);
        wait_data();
        wait_fetch();
        d_last = 16'h5A5A;
        f_last = 16'h1357;

        // Write: d_rdata must keep its previous read value.
        @(negedge clk);
        start_data(1'b1, 16'h1234, 16'hBEEF, 16'h0, 0, 1, 2, d_last);
        wait_data();

        // Back-to-back writes at minimum spacing.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            v = 16'($urandom);
            start_data(1'b1, a, v, 16'h0, 0, 1, 2, d_last);
            wait_data();
        end

        // Reads with assorted latencies, alternating requesters.
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(1, 6));
            a   = 16'($urandom);
            v   = 16'($urandom);
            @(negedge clk);
            if (i % 2 == 0) begin
                start_data(1'b0, a, 16'h0, v, lat, 1, 2 + lat, v);
                wait_data();
                d_last = v;
            end else begin
                start_fetch(a, v, lat, 1, 2 + lat);
                wait_fetch();
                f_last = v;
            end
        end

        // Stray return while IDLE.
        @(negedge clk);
        spur_data = 16'hFFFF;
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_if_rdata", bus.if_rdata, f_last);
        check("spur_d_rdata", bus.d_rdata, d_last);
        check("pre_timeout_err", bus.mem_err, 0);

        // Timeout: no return, zero data, sticky error.
        @(negedge clk);
        start_data(1'b0, 16'h3000, 16'h0, 16'h0, -1, 1, 3 + TO, 16'h0);
        wait_data();
        d_last = 16'h0;
        check("timeout_err", bus.mem_err, 1);
        @(negedge clk);
        start_fetch(16'h0050, 16'hC0DE, 3, 1, 5);
        wait_fetch();
        f_last = 16'hC0DE;
        check("err_sticky", bus.mem_err, 1);

        // Reset during RD_WAIT, with the memory answering late.
        @(negedge clk);
        start_data(1'b0, 16'h4000, 16'h0, 16'h7777, 10, 1, 12, 16'h7777);
        repeat (4) @(negedge clk);
        rst       = 1'b1;
        bus.d_req = 1'b0;
        dq.delete();
        #1;
        check("mid_rst_mem_en", bus.mem_en, 0);
        check("mid_rst_d_done", bus.d_done, 0);
        check("mid_rst_if_rdata", bus.if_rdata, 0);
        check("mid_rst_d_rdata", bus.d_rdata, 0);
        check("mid_rst_mem_err", bus.mem_err, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("late_valid_d_rdata", bus.d_rdata, 0);
        @(negedge clk);
        start_data(1'b0, 16'h4002, 16'h0, 16'h2468, 2, 1, 4, 16'h2468);
        wait_data();
        check("post_rst_err", bus.mem_err, 0);

        repeat (3) @(negedge clk);
        check("cmdq_drained", cmdq.size(), 0);
        check("fq_drained", fq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
